// File: rtl/pio_irq_bank_if.sv
// Avalon-MM slave bus bundle for pio_irq_bank: 3-bit word address, 32-bit data,
// fixed read latency of one cycle.
interface pio_irq_bank_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/pio_irq_bank.sv
// Avalon-MM parallel I/O bank: output register with atomic set/clear, synchronised
// inputs, per-bit edge capture and masked level IRQ. Optional input debounce: PIO_DEBOUNCE_EN.
module pio_irq_bank #(
    parameter int unsigned IN_WIDTH        = 2,
    parameter int unsigned OUT_WIDTH       = 16,
    parameter int unsigned EDGE_MODE       = 0,
    parameter logic        IN_IDLE         = 1'b1,
    parameter logic [31:0] OUT_RESET       = 32'h0,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    pio_irq_bank_if.slave        avs,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out,
    output logic                 irq
);
    localparam logic [IN_WIDTH-1:0]  IDLE_V    = {IN_WIDTH{IN_IDLE}};
    localparam logic [OUT_WIDTH-1:0] OUT_RST_V = OUT_RESET[OUT_WIDTH-1:0];

    logic [IN_WIDTH-1:0]  r_sync1, r_sync2, r_prev, r_edge_cap, r_mask;
    logic [IN_WIDTH-1:0]  w_in_val, w_edge, w_clr;
    logic [OUT_WIDTH-1:0] r_out;
    logic [31:0]          r_rdata, w_rd_mux;
    logic                 r_irq;
    logic                 w_wr_out, w_wr_mask, w_wr_set, w_wr_clr;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= IDLE_V;
            r_sync2 <= IDLE_V;
        end else begin
            r_sync1 <= pio_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] r_deb;
    logic [CW-1:0]       r_cnt [IN_WIDTH];

    // A bit is accepted only after it has differed from the debounced value for
    // DEBOUNCE_CYCLES consecutive cycles; any return to agreement restarts the count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_deb <= IDLE_V;
            for (int unsigned i = 0; i < IN_WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < IN_WIDTH; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == DB_LAST) begin
                        r_deb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_in_val = r_deb;
`else
    assign w_in_val = r_sync2;
`endif

    always_comb begin
        w_edge = '0;
        case (EDGE_MODE)
            0:       w_edge = ~w_in_val & r_prev;
            1:       w_edge = w_in_val & ~r_prev;
            default: w_edge = (w_in_val & ~r_prev) | (~w_in_val & r_prev);
        endcase
    end

    assign w_wr_out  = avs.avs_write && (avs.avs_address == 3'd1);
    assign w_wr_mask = avs.avs_write && (avs.avs_address == 3'd2);
    assign w_wr_set  = avs.avs_write && (avs.avs_address == 3'd4);
    assign w_wr_clr  = avs.avs_write && (avs.avs_address == 3'd5);
    assign w_clr     = (avs.avs_write && (avs.avs_address == 3'd3))
                       ? avs.avs_writedata[IN_WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (avs.avs_address)
            3'd0:    w_rd_mux[IN_WIDTH-1:0]  = w_in_val;
            3'd1:    w_rd_mux[OUT_WIDTH-1:0] = r_out;
            3'd2:    w_rd_mux[IN_WIDTH-1:0]  = r_mask;
            3'd3:    w_rd_mux[IN_WIDTH-1:0]  = r_edge_cap;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_prev     <= IDLE_V;
            r_edge_cap <= '0;
            r_mask     <= '0;
            r_out      <= OUT_RST_V;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev <= w_in_val;
            // New edge is OR'd in after the W1C so a coincident edge keeps the bit set.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_wr_mask) r_mask <= avs.avs_writedata[IN_WIDTH-1:0];
            if (w_wr_out)
                r_out <= avs.avs_writedata[OUT_WIDTH-1:0];
            else if (w_wr_set)
                r_out <= r_out | avs.avs_writedata[OUT_WIDTH-1:0];
            else if (w_wr_clr)
                r_out <= r_out & ~avs.avs_writedata[OUT_WIDTH-1:0];
            if (avs.avs_read) r_rdata <= w_rd_mux;
            r_irq <= |(r_edge_cap & r_mask);
        end
    end

    assign avs.avs_readdata = r_rdata;
    assign pio_out          = r_out;
    assign irq              = r_irq;
endmodule

// File: doc/pio_irq_bank.md
Name: pio_irq_bank

Overview:
- Parametrised Avalon-MM parallel I/O bank; successor to the fixed per-function PIO exports (keycode, hex_digits, leds, keys) in the lab8 SoC.
- One instance provides a configurable-width output register with atomic set/clear, and a configurable-width synchronised input port.
- Adds per-bit edge capture, an interrupt mask and a level IRQ to the Nios II, none of which the current exports have.
- Sits on the SoC Avalon bus; the conduit pins go to board keys, LEDs and hex drivers.

Parameters:
- IN_WIDTH, 2, input bit count; legal range 1..32.
- OUT_WIDTH, 16, output bit count; legal range 1..32.
- EDGE_MODE, 0, edge type captured: 0 = falling, 1 = rising, 2 = both.
- IN_IDLE, 1, idle level of every input bit, replicated; reset value of synchroniser and history flops.
- OUT_RESET, 0, reset value of DATA_OUT, zero-extended/truncated to OUT_WIDTH.
- DEBOUNCE_CYCLES, 50000, stable cycles required before an input change is accepted; used only with PIO_DEBOUNCE_EN.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data; fixed read latency of 1 cycle
- pio_in  in  IN_WIDTH  asynchronous external inputs
- pio_out  out  OUT_WIDTH  registered outputs
- irq  out  1  level interrupt, active high

Behaviour:
- Reset (async assert, sync deassert by the SoC reset controller):
  - avs_readdata = 0; pio_out = OUT_RESET.
  - IRQ_MASK = 0; EDGE_CAP = 0; irq = 0.
  - Synchroniser and history flops = IN_IDLE, so no edge is captured after reset.
- Input path:
  - 2-flop synchroniser per bit produces in_sync.
  - in_val = in_sync, or the debounced value with the option enabled.
  - in_prev = in_val delayed 1 cycle.
- Edge detect per bit:
  - rise = in_val & ~in_prev; fall = ~in_val & in_prev.
  - Mode select: EDGE_MODE 0 uses fall, 1 uses rise, 2 uses rise|fall.
  - Detected edge sets the EDGE_CAP bit on the next clock.
  - Latency pin toggle -> EDGE_CAP set = 3 cycles without debounce.
- Register map (word addresses):
  - 0 DATA_IN: RO, in_val. Writes ignored.
  - 1 DATA_OUT: RW; a write loads writedata[OUT_WIDTH-1:0].
  - 2 IRQ_MASK: RW, IN_WIDTH bits.
  - 3 EDGE_CAP: read returns captured bits; a write of 1 clears the bit, 0 leaves it unchanged.
  - 4 OUT_SET: WO; DATA_OUT |= writedata. Reads return 0.
  - 5 OUT_CLR: WO; DATA_OUT &= ~writedata. Reads return 0.
  - 6, 7: reserved; read 0, writes ignored.
- Read timing:
  - avs_readdata is registered on the cycle avs_read is high; valid the next cycle; unused upper bits are 0.
  - When avs_read is low, avs_readdata holds its last value.
- Write timing: takes effect on the clock edge where avs_write is high; pio_out changes on that same edge.
- avs_read and avs_write asserted together: both performed; the read returns the pre-write value.
- EDGE_CAP clear and a new edge on the same bit in the same cycle: the edge wins and the bit stays 1.
- irq = |(EDGE_CAP & IRQ_MASK), registered, so irq rises 1 cycle after a masked EDGE_CAP bit sets.
- Clearing EDGE_CAP or IRQ_MASK drops irq 1 cycle after the write edge.
- Reset mid-operation: all state returns to reset values immediately; an in-flight read returns 0.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- Defined:
  - Per-bit counter of width clog2(DEBOUNCE_CYCLES+1).
  - While in_sync != debounced bit, the counter increments; it clears when they match again.
  - At count DEBOUNCE_CYCLES-1 the debounced bit takes in_sync and the counter clears.
  - in_val = debounced value; debounced bits reset to IN_IDLE.
  - Pulses shorter than DEBOUNCE_CYCLES are discarded.
- Not defined: no counters are built, in_val = in_sync, and DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset with OUT_RESET=16'h00A5 -> pio_out=16'h00A5, irq=0, read addr 3 returns 0, read addr 0 returns 2'b11.
- Write 0x1234 to addr 1, write 0x0F00 to addr 4, write 0x0030 to addr 5 -> pio_out=0x1F04; read addr 1 returns 0x00001F04 one cycle after avs_read.
- EDGE_MODE=0, IRQ_MASK=2'b10, drive pio_in[1] 1->0 -> EDGE_CAP=2'b10 after 3 cycles, irq=1 one cycle later; write 2'b10 to addr 3 -> irq=0 the cycle after.
- Falling edge on pio_in[0] with IRQ_MASK=2'b10 -> EDGE_CAP=2'b01, irq stays 0; then write IRQ_MASK=2'b11 -> irq=1 next cycle.
- Edge arrives in the same cycle as a W1C of the same bit -> EDGE_CAP bit remains 1 and irq stays asserted.
- PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 5-cycle low glitch -> no capture, DATA_IN stays 2'b11; 20-cycle low -> DATA_IN[0]=0 and EDGE_CAP[0]=1.
